sram_write_auditor: RTL and testbench

Synthesizable, parametrised successor to the bench-side SRAM write monitor. It sits beside the project top-level, tapping the SRAM write bus (we_n, address, write data). It checks every write against one allowed address window. It tracks per-location coverage in an on-chip bitmap to find double writes and, after a scan, unwritten locations. It also folds the write stream into a signature, so a hardware run can be compared against a golden value without a bench.

---
 rtl/sram_audit_pkg.sv | 11 +
 rtl/sram_audit_bitmap.sv | 22 ++
 rtl/sram_write_auditor.sv | 197 +++++++++++++++++++
 tb/tb_sram_write_auditor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_audit_pkg.sv
// sram_audit_pkg: shared state encoding and bitmap masking helper for the SRAM write auditor
package sram_audit_pkg;

    typedef enum logic [1:0] {S_CLEAR, S_MONITOR, S_DRAIN, S_SCAN} state_t;

    // Valid-bit mask of the final bitmap word; a full word when the window is a multiple of 16
    function automatic logic [15:0] last_mask(int win_size);
        return (win_size % 16 == 0) ? 16'hFFFF : 16'((17'd1 << (win_size % 16)) - 17'd1);
    endfunction

endpackage

// File: rtl/sram_audit_bitmap.sv
// sram_audit_bitmap: WORDS x 16 simple dual-port coverage RAM, 1-cycle read, old data on read-during-write
module sram_audit_bitmap #(
    parameter int WORDS = 2,
    parameter int AW    = 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [WORDS];

    // Registered read sees the pre-write contents when both ports hit the same word
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sram_write_auditor.sv
// sram_write_auditor: taps the SRAM write bus, checks the address window, tracks coverage and signs the stream
module sram_write_auditor
    import sram_audit_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int WIN_LO = 146944,
    parameter int WIN_HI = 262143,
    parameter int CNT_W  = 20
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Clear_i,
    input  logic                     SRAM_we_n_i,
    input  logic [ADDR_W-1:0]        SRAM_address_i,
    input  logic [DATA_W-1:0]        SRAM_write_data_i,
    input  logic                     Scan_start_i,
    output logic                     Ready_o,
    output logic                     Scan_done_o,
    output logic [CNT_W-1:0]         Write_count_o,
    output logic [CNT_W-1:0]         Oow_count_o,
    output logic [CNT_W-1:0]         Multi_count_o,
    output logic [CNT_W-1:0]         Unwritten_count_o,
    output logic [ADDR_W-1:0]        First_oow_addr_o,
    output logic                     First_oow_valid_o,
    output logic                     Miss_flag_o,
    output logic [ADDR_W+DATA_W-1:0] Signature_o
);

    localparam int WIN_SIZE = WIN_HI - WIN_LO + 1;
    localparam int WORDS    = (WIN_SIZE + 15) / 16;
    localparam int SIG_W    = ADDR_W + DATA_W;
    localparam int AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW       = $clog2(WORDS + 1);
    localparam logic [ADDR_W:0] LO        = (ADDR_W+1)'(WIN_LO);
    localparam logic [ADDR_W:0] HI        = (ADDR_W+1)'(WIN_HI);
    localparam logic [PW-1:0]   WORDS_P   = PW'(WORDS);
    localparam logic [PW-1:0]   LAST_P    = PW'(WORDS - 1);
    localparam logic [15:0]     LAST_MASK = last_mask(WIN_SIZE);

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic                s1_v_q, s2_v_q, sc_v_q, sc_last_q, done_q, fv_q, miss_q;
    logic [AW-1:0]       s1_word_q, s2_word_q;
    logic [3:0]          s1_bit_q;
    logic [15:0]         s2_data_q;
    logic [CNT_W-1:0]    wc_q, oow_q, multi_q, uw_q, uw_d;
    logic [ADDR_W-1:0]   fa_q, idx_d;
    logic [SIG_W-1:0]    sig_q;
    logic                wr_d, in_win_d, track_d, dup_d, ram_we_d;
    logic [AW-1:0]       word_d, ram_waddr_d, ram_raddr_d;
    logic [15:0]         rd_data, cur_d, merged_d, ram_wdata_d, zero_bits_d;
    logic [4:0]          zeros_d;
    logic [CNT_W:0]      uw_sum_d;

    function automatic logic [CNT_W-1:0] inc(logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction

    // Window decode, RMW merge with bypass from the word committed last cycle, and scan zero counting
    always_comb begin
        wr_d        = ~SRAM_we_n_i;
        in_win_d    = ({1'b0, SRAM_address_i} >= LO) && ({1'b0, SRAM_address_i} <= HI);
        idx_d       = SRAM_address_i - LO[ADDR_W-1:0];
        word_d      = AW'(idx_d >> 4);
        track_d     = wr_d && in_win_d && state_q == S_MONITOR;
        cur_d       = (s2_v_q && s2_word_q == s1_word_q) ? s2_data_q : rd_data;
        merged_d    = cur_d | (16'h1 << s1_bit_q);
        dup_d       = |(cur_d & (16'h1 << s1_bit_q));
        ram_we_d    = (state_q == S_CLEAR) ? 1'b1 : s1_v_q;
        ram_waddr_d = (state_q == S_CLEAR) ? AW'(ptr_q) : s1_word_q;
        ram_wdata_d = (state_q == S_CLEAR) ? 16'h0 : merged_d;
        ram_raddr_d = (state_q == S_SCAN) ? AW'(ptr_q) : word_d;
        zero_bits_d = ~rd_data & (sc_last_q ? LAST_MASK : 16'hFFFF);
        zeros_d     = '0;
        for (int i = 0; i < 16; i++) zeros_d += 5'(zero_bits_d[i]);
        uw_sum_d    = {1'b0, uw_q} + {{(CNT_W-4){1'b0}}, zeros_d};
        uw_d        = uw_sum_d[CNT_W] ? '1 : uw_sum_d[CNT_W-1:0];
    end

    sram_audit_bitmap #(.WORDS(WORDS), .AW(AW)) u_bitmap (
        .clk_i   (Clock),
        .we_i    (ram_we_d),
        .waddr_i (ram_waddr_d),
        .wdata_i (ram_wdata_d),
        .raddr_i (ram_raddr_d),
        .rdata_o (rd_data)
    );

    // Control FSM plus bus statistics; Clear_i behaves like reset apart from the RAM contents
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_CLEAR;
            ptr_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_word_q <= '0;
            s1_bit_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_word_q <= '0;
            s2_data_q <= '0;
            sc_v_q    <= 1'b0;
            sc_last_q <= 1'b0;
            done_q    <= 1'b0;
            wc_q      <= '0;
            oow_q     <= '0;
            multi_q   <= '0;
            uw_q      <= '0;
            fa_q      <= '0;
            fv_q      <= 1'b0;
            miss_q    <= 1'b0;
            sig_q     <= '0;
        end else if (Clear_i) begin
            state_q   <= S_CLEAR;
            ptr_q     <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            sc_v_q    <= 1'b0;
            sc_last_q <= 1'b0;
            done_q    <= 1'b0;
            wc_q      <= '0;
            oow_q     <= '0;
            multi_q   <= '0;
            uw_q      <= '0;
            fa_q      <= '0;
            fv_q      <= 1'b0;
            miss_q    <= 1'b0;
            sig_q     <= '0;
        end else begin
            if (wr_d) begin
                wc_q  <= inc(wc_q);
                sig_q <= {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ {SRAM_address_i, SRAM_write_data_i};
                if (!in_win_d) begin
                    oow_q <= inc(oow_q);
                    if (!fv_q) begin
                        fa_q <= SRAM_address_i;
                        fv_q <= 1'b1;
                    end
                end else if (state_q != S_MONITOR) begin
                    miss_q <= 1'b1;
                end
            end
            s1_v_q    <= track_d;
            s1_word_q <= word_d;
            s1_bit_q  <= idx_d[3:0];
            s2_v_q    <= s1_v_q;
            s2_word_q <= s1_word_q;
            s2_data_q <= merged_d;
            if (s1_v_q && dup_d) multi_q <= inc(multi_q);
            sc_v_q    <= state_q == S_SCAN && ptr_q < WORDS_P;
            sc_last_q <= ptr_q == LAST_P;
            if (sc_v_q) uw_q <= uw_d;
            done_q    <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_P) begin
                        state_q <= S_MONITOR;
                        ptr_q   <= '0;
                    end
                end
                S_MONITOR: if (Scan_start_i) begin
                    state_q <= S_DRAIN;
                    ptr_q   <= '0;
                    uw_q    <= '0;
                end
                S_DRAIN: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PW'(1)) begin
                        state_q <= S_SCAN;
                        ptr_q   <= '0;
                    end
                end
                S_SCAN: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == WORDS_P) begin
                        state_q <= S_MONITOR;
                        ptr_q   <= '0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign Ready_o           = state_q == S_MONITOR;
    assign Scan_done_o       = done_q;
    assign Write_count_o     = wc_q;
    assign Oow_count_o       = oow_q;
    assign Multi_count_o     = multi_q;
    assign Unwritten_count_o = uw_q;
    assign First_oow_addr_o  = fa_q;
    assign First_oow_valid_o = fv_q;
    assign Miss_flag_o       = miss_q;
    assign Signature_o       = sig_q;

endmodule

// File: tb/tb_sram_write_auditor.sv
// tb_sram_write_auditor: scoreboard bench; scan results checked against an address-level coverage model
module tb_sram_write_auditor;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, we_n = 1'b1, scan = 1'b0;
    logic [17:0] addr = '0;
    logic [15:0] data = '0;
    logic        Ready_o, Scan_done_o, First_oow_valid_o, Miss_flag_o;
    logic [7:0]  Write_count_o, Oow_count_o, Multi_count_o, Unwritten_count_o;
    logic [17:0] First_oow_addr_o;
    logic [33:0] Signature_o;

    sram_write_auditor #(.ADDR_W(18), .DATA_W(16), .WIN_LO(16), .WIN_HI(47), .CNT_W(8)) dut (
        .Clock             (clk),
        .Reset             (rst),
        .Clear_i           (clr),
        .SRAM_we_n_i       (we_n),
        .SRAM_address_i    (addr),
        .SRAM_write_data_i (data),
        .Scan_start_i      (scan),
        .Ready_o           (Ready_o),
        .Scan_done_o       (Scan_done_o),
        .Write_count_o     (Write_count_o),
        .Oow_count_o       (Oow_count_o),
        .Multi_count_o     (Multi_count_o),
        .Unwritten_count_o (Unwritten_count_o),
        .First_oow_addr_o  (First_oow_addr_o),
        .First_oow_valid_o (First_oow_valid_o),
        .Miss_flag_o       (Miss_flag_o),
        .Signature_o       (Signature_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wc, oow, multi, unw;
        logic [17:0] fa;
        bit          fv, miss;
        logic [33:0] sig;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, failures = 0, done_cnt = 0;
    int          m_wc, m_oow, m_multi;
    logic [17:0] m_fa;
    bit          m_fv, m_miss, tracking;
    logic [33:0] m_sig;
    bit          written[64];

    function automatic int sat(int x);
        return x > 255 ? 255 : x;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_wc = 0; m_oow = 0; m_multi = 0; m_fa = '0; m_fv = 0; m_miss = 0; m_sig = '0;
        tracking = 0;
        for (int i = 0; i < 64; i++) written[i] = 0;
    endtask

    task automatic model_write(logic [17:0] a, logic [15:0] d);
        m_wc++;
        m_sig = {m_sig[32:0], m_sig[33]} ^ {a, d};
        if (a < 16 || a > 47) begin
            m_oow++;
            if (!m_fv) begin
                m_fa = a;
                m_fv = 1;
            end
        end else if (tracking) begin
            if (written[a]) m_multi++;
            written[a] = 1;
        end else begin
            m_miss = 1;
        end
    endtask

    task automatic wr(logic [17:0] a, logic [15:0] d);
        we_n = 1'b0; addr = a; data = d;
        model_write(a, d);
        tick();
        we_n = 1'b1;
    endtask

    task automatic do_scan();
        exp_t e;
        int   start;
        e.unw = 0;
        for (int a = 16; a <= 47; a++) if (!written[a]) e.unw++;
        e.wc = sat(m_wc); e.oow = sat(m_oow); e.multi = sat(m_multi);
        e.fa = m_fa; e.fv = m_fv; e.miss = m_miss; e.sig = m_sig;
        q.push_back(e);
        start = done_cnt;
        scan = 1'b1;
        tick();
        scan = 1'b0;
        for (int i = 0; i < 40 && done_cnt == start; i++) tick();
        chk("scan_done_seen", 64'(done_cnt - start), 1);
        chk("scan_done_pulse", Scan_done_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_clear();
        chk("clr_ready0", Ready_o, 0);
        chk("clr_wc", Write_count_o, 0);
        chk("clr_oow", Oow_count_o, 0);
        chk("clr_multi", Multi_count_o, 0);
        chk("clr_sig", Signature_o, 0);
        chk("clr_fv", First_oow_valid_o, 0);
        chk("clr_miss", Miss_flag_o, 0);
        tick();
        chk("clr_ready1", Ready_o, 0);
        tick();
        chk("clr_ready2", Ready_o, 1);
        tracking = 1;
    endtask

    // Scoreboard monitor: every scan completion is matched against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (Scan_done_o) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scan_unexpected actual=done required=no_done");
            end else begin
                e = q.pop_front();
                chk("sb_wc", Write_count_o, e.wc);
                chk("sb_oow", Oow_count_o, e.oow);
                chk("sb_multi", Multi_count_o, e.multi);
                chk("sb_unwritten", Unwritten_count_o, e.unw);
                chk("sb_fv", First_oow_valid_o, e.fv);
                if (e.fv) chk("sb_fa", First_oow_addr_o, e.fa);
                chk("sb_miss", Miss_flag_o, e.miss);
                chk("sb_sig", Signature_o, e.sig);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] last;
        int          n;
        model_clear();
        do_reset();
        chk("rst_ready", Ready_o, 0);
        chk("rst_done", Scan_done_o, 0);
        chk("rst_wc", Write_count_o, 0);
        chk("rst_oow", Oow_count_o, 0);
        chk("rst_multi", Multi_count_o, 0);
        chk("rst_unw", Unwritten_count_o, 0);
        chk("rst_fv", First_oow_valid_o, 0);
        chk("rst_miss", Miss_flag_o, 0);
        chk("rst_sig", Signature_o, 0);
        tick();
        chk("rst_ready_c1", Ready_o, 0);
        tick();
        chk("rst_ready_c2", Ready_o, 1);
        tracking = 1;

        for (int a = 16; a <= 47; a++) wr(18'(a), 16'($urandom));
        do_scan();
        chk("full_unw", Unwritten_count_o, 0);

        do_clear();
        wr(18'd20, 16'h1111);
        wr(18'd20, 16'h2222);
        wr(18'd21, 16'h3333);
        do_scan();
        chk("bypass_multi", Multi_count_o, 1);
        chk("bypass_unw", Unwritten_count_o, 30);

        do_clear();
        wr(18'd5, 16'h0001);
        wr(18'd60, 16'h0002);
        chk("oow_count", Oow_count_o, 2);
        chk("oow_addr", First_oow_addr_o, 5);
        chk("oow_valid", First_oow_valid_o, 1);
        do_scan();

        do_clear();
        wr(18'd16, 16'hABCD);
        chk("sig_single", Signature_o, 34'h0_0010_ABCD);
        do_clear();

        do_reset();
        wr(18'd16, 16'h5A5A);
        chk("miss_flag", Miss_flag_o, 1);
        chk("miss_wc", Write_count_o, 1);
        chk("miss_ready", Ready_o, 0);
        tick();
        chk("miss_ready_up", Ready_o, 1);
        tracking = 1;
        do_scan();
        chk("miss_unw", Unwritten_count_o, 32);

        for (int r = 0; r < 6; r++) begin
            do_clear();
            n = $urandom_range(20, 60);
            last = 18'd16;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0) last = 18'($urandom_range(0, 63));
                wr(last, 16'($urandom));
                repeat ($urandom_range(0, 1)) tick();
            end
            do_scan();
        end

        do_clear();
        for (int i = 0; i < 300; i++) wr(18'($urandom_range(16, 47)), 16'($urandom));
        do_scan();
        chk("sat_wc", Write_count_o, 255);

        repeat (3) tick();
        chk("sb_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
